lcd_scanline_fx: RTL and testbench

LCD_SCANLINE_FX -- requirements
Module: lcd_scanline_fx

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/sl_shade.sv | 23 ++
 rtl/lcd_scanline_fx.sv | 144 ++++++++++++++
 tb/tb_lcd_scanline_fx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD scanline effect: sl_mode encodings, line counter width
// and the per-channel darkening function.
package lcd_pkg;

    localparam int LINE_W = 10;

    localparam logic [1:0] SL_OFF = 2'd0;
    localparam logic [1:0] SL_25  = 2'd1;
    localparam logic [1:0] SL_50  = 2'd2;
    localparam logic [1:0] SL_75  = 2'd3;

    // Darkening keeps 75%, 50% or 25% of the channel; all terms stay within 8 bits.
    function automatic logic [7:0] shade(input logic [1:0] mode, input logic [7:0] chan);
        logic [7:0] res;
        case (mode)
            SL_25:   res = chan - (chan >> 2);
            SL_50:   res = chan >> 1;
            SL_75:   res = chan >> 2;
            default: res = chan;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sl_shade.sv
// One registered 8-bit colour channel: applies the scanline darkening selected by mode
// and forces zero while blanked.
module sl_shade
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       blank,
    input  logic [7:0] chan,
    output logic [7:0] shaded
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shaded <= 8'd0;
        end else if (en) begin
            shaded <= blank ? 8'd0 : shade(mode, chan);
        end
    end

endmodule

// File: rtl/lcd_scanline_fx.sv
// Two-stage scanline post-processor for the LCD video path: delays syncs, splits blanking,
// counts lines and darkens odd lines. Darkening is built only when SCANLINE_FX_EN is defined.
module lcd_scanline_fx
    import lcd_pkg::*;
#(
    parameter logic [LINE_W-1:0] LINE_MAX = 10'd1023
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              pce,
    input  logic [1:0]        sl_mode,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_in,
    input  logic [7:0]        r_in,
    input  logic [7:0]        g_in,
    input  logic [7:0]        b_in,
    output logic              hs,
    output logic              vs,
    output logic              hblank,
    output logic              vblank,
    output logic              de,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic [LINE_W-1:0] line_cnt,
    output logic              odd_line
);

    logic              hs_q;
    logic              vs_q;
    logic              blank_q;
    logic              vblank_q;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic [7:0]        b_q;
    logic [LINE_W-1:0] cnt_q;
    logic              odd_q;
    logic [1:0]        sl_mode_q;
    logic              hs_rise;
    logic              vs_rise;
    logic [1:0]        shade_mode;

    // hs_q/vs_q double as the edge history: they hold the previous hs_in/vs_in.
    assign hs_rise = hs_in & ~hs_q;
    assign vs_rise = vs_in & ~vs_q;

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            blank_q   <= 1'b1;
            vblank_q  <= 1'b1;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
            cnt_q     <= '0;
            odd_q     <= 1'b0;
            sl_mode_q <= SL_OFF;
        end else if (pce) begin
            hs_q    <= hs_in;
            vs_q    <= vs_in;
            blank_q <= blank_in;
            r_q     <= r_in;
            g_q     <= g_in;
            b_q     <= b_in;
            if (vs_rise) begin
                cnt_q     <= '0;
                odd_q     <= 1'b0;
                vblank_q  <= 1'b1;
                sl_mode_q <= sl_mode;
            end else begin
                if (hs_rise) begin
                    if (cnt_q != LINE_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    odd_q <= ~odd_q;
                end
                if (!blank_in) begin
                    vblank_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            hs       <= 1'b0;
            vs       <= 1'b0;
            de       <= 1'b0;
            hblank   <= 1'b0;
            vblank   <= 1'b1;
            line_cnt <= '0;
            odd_line <= 1'b0;
        end else if (pce) begin
            hs       <= hs_q;
            vs       <= vs_q;
            de       <= ~blank_q;
            hblank   <= blank_q & ~vblank_q;
            vblank   <= vblank_q;
            line_cnt <= cnt_q;
            odd_line <= odd_q;
        end
    end

`ifdef SCANLINE_FX_EN
    assign shade_mode = odd_q ? sl_mode_q : SL_OFF;
`else
    logic unused_mode;
    assign unused_mode = ^sl_mode_q;
    assign shade_mode  = SL_OFF;
`endif

    sl_shade u_shade_r (
        .clk     (pclk),
        .reset_n (reset_n),
        .en      (pce),
        .mode    (shade_mode),
        .blank   (blank_q),
        .chan    (r_q),
        .shaded  (r)
    );

    sl_shade u_shade_g (
        .clk     (pclk),
        .reset_n (reset_n),
        .en      (pce),
        .mode    (shade_mode),
        .blank   (blank_q),
        .chan    (g_q),
        .shaded  (g)
    );

    sl_shade u_shade_b (
        .clk     (pclk),
        .reset_n (reset_n),
        .en      (pce),
        .mode    (shade_mode),
        .blank   (blank_q),
        .chan    (b_q),
        .shaded  (b)
    );

endmodule

// File: tb/tb_lcd_scanline_fx.sv
// Directed bench for lcd_scanline_fx; expectations follow SCANLINE_FX_EN of the build.
module tb_lcd_scanline_fx;

`ifdef SCANLINE_FX_EN
    localparam bit FX = 1'b1;
`else
    localparam bit FX = 1'b0;
`endif

    logic       pclk = 1'b0;
    logic       reset_n;
    logic       pce;
    logic [1:0] sl_mode;
    logic       hs_in, vs_in, blank_in;
    logic [7:0] r_in, g_in, b_in;
    logic       hs, vs, hblank, vblank, de;
    logic [7:0] r, g, b;
    logic [9:0] line_cnt;
    logic       odd_line;

    int checks = 0;
    int failures = 0;

    lcd_scanline_fx dut (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .pce      (pce),
        .sl_mode  (sl_mode),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
        .blank_in (blank_in),
        .r_in     (r_in),
        .g_in     (g_in),
        .b_in     (b_in),
        .hs       (hs),
        .vs       (vs),
        .hblank   (hblank),
        .vblank   (vblank),
        .de       (de),
        .r        (r),
        .g        (g),
        .b        (b),
        .line_cnt (line_cnt),
        .odd_line (odd_line)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input logic h, input logic v, input logic bl,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        hs_in = h; vs_in = v; blank_in = bl;
        r_in = rr; g_in = gg; b_in = bb;
    endtask

    task automatic hs_pulse();
        drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00); step();
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00); step();
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00); step();
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00); step();
    endtask

    // Active pixel held for two cycles so it is on the outputs afterwards.
    task automatic pix(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        drive(1'b0, 1'b0, 1'b0, rr, gg, bb);
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pce = 1'b1; sl_mode = 2'd3;
        drive(1'b1, 1'b1, 1'b0, 8'hAA, 8'hBB, 8'hCC);
        step();
        checks++;
        if ({hs, vs, de, hblank, vblank, odd_line, line_cnt, r, g, b} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 24'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h",
                     {hs, vs, de, hblank, vblank, odd_line, line_cnt, r, g, b},
                     {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 24'h0});
        end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        step();
    endtask

    task automatic test_latency();
        sl_mode = 2'd0;
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00); step();
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00); step();
        checks++;
        if ({vs, vblank, de, hblank, line_cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0}) begin
            failures++;
            $display("FAIL vs_out got=%h exp=%h", {vs, vblank, de, hblank, line_cnt},
                     {1'b1, 1'b1, 1'b0, 1'b0, 10'd0});
        end
        pix(8'h10, 8'h20, 8'h30);
        checks++;
        if ({vs, vblank, de, r} !== {1'b0, 1'b0, 1'b1, 8'h10}) begin
            failures++;
            $display("FAIL first_active got=%h exp=%h", {vs, vblank, de, r}, {1'b0, 1'b0, 1'b1, 8'h10});
        end
        drive(1'b0, 1'b0, 1'b0, 8'h41, 8'h42, 8'h43); step();
        checks++;
        if ({r, g, b} !== 24'h102030) begin
            failures++;
            $display("FAIL lat_one_cycle got=%h exp=%h", {r, g, b}, 24'h102030);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h52, 8'h53, 8'h54); step();
        checks++;
        if ({r, g, b} !== 24'h414243) begin
            failures++;
            $display("FAIL lat_two_cycles got=%h exp=%h", {r, g, b}, 24'h414243);
        end
        pce = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 8'h63, 8'h64, 8'h65);
        step(); step(); step();
        checks++;
        if ({hs, de, line_cnt, r, g, b} !== {1'b0, 1'b1, 10'd0, 24'h414243}) begin
            failures++;
            $display("FAIL pce_hold got=%h exp=%h", {hs, de, line_cnt, r, g, b},
                     {1'b0, 1'b1, 10'd0, 24'h414243});
        end
        pce = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h63, 8'h64, 8'h65);
        step();
        checks++;
        if ({r, g, b} !== 24'h525354) begin
            failures++;
            $display("FAIL pce_resume got=%h exp=%h", {r, g, b}, 24'h525354);
        end
        step();
        checks++;
        if ({r, g, b} !== 24'h636465) begin
            failures++;
            $display("FAIL pce_resume2 got=%h exp=%h", {r, g, b}, 24'h636465);
        end
    endtask

    task automatic test_shade();
        logic [1:0]  modes [3];
        logic [23:0] shaded [3];
        logic [23:0] exp_rgb;
        modes[0] = 2'd2; shaded[0] = 24'h7F4001;
        modes[1] = 2'd1; shaded[1] = 24'hC06003;
        modes[2] = 2'd3; shaded[2] = 24'h3F2000;
        for (int i = 0; i < 3; i++) begin
            sl_mode = modes[i];
            vs_pulse();
            sl_mode = 2'd0;
            pix(8'hFF, 8'h80, 8'h03);
            checks++;
            if ({line_cnt, odd_line, r, g, b} !== {10'd0, 1'b0, 24'hFF8003}) begin
                failures++;
                $display("FAIL shade_line0 mode=%0d got=%h exp=%h", modes[i],
                         {line_cnt, odd_line, r, g, b}, {10'd0, 1'b0, 24'hFF8003});
            end
            hs_pulse();
            pix(8'hFF, 8'h80, 8'h03);
            exp_rgb = FX ? shaded[i] : 24'hFF8003;
            checks++;
            if ({line_cnt, odd_line, r, g, b} !== {10'd1, 1'b1, exp_rgb}) begin
                failures++;
                $display("FAIL shade_line1 mode=%0d got=%h exp=%h", modes[i],
                         {line_cnt, odd_line, r, g, b}, {10'd1, 1'b1, exp_rgb});
            end
            drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF); step(); step();
            checks++;
            if ({de, hblank, vblank, r, g, b} !== {1'b0, 1'b1, 1'b0, 24'h0}) begin
                failures++;
                $display("FAIL blank_force mode=%0d got=%h exp=%h", modes[i],
                         {de, hblank, vblank, r, g, b}, {1'b0, 1'b1, 1'b0, 24'h0});
            end
        end
    endtask

    task automatic test_mode_latch();
        logic [7:0] exp_r;
        sl_mode = 2'd0;
        vs_pulse();
        for (int i = 0; i < 101; i++) hs_pulse();
        sl_mode = 2'd3;
        pix(8'hFF, 8'hFF, 8'hFF);
        checks++;
        if ({line_cnt, odd_line, r} !== {10'd101, 1'b1, 8'hFF}) begin
            failures++;
            $display("FAIL latch_midframe got=%h exp=%h", {line_cnt, odd_line, r}, {10'd101, 1'b1, 8'hFF});
        end
        vs_pulse();
        for (int ln = 0; ln < 6; ln++) begin
            pix(8'hFF, 8'hFF, 8'hFF);
            exp_r = (FX && (ln % 2 == 1)) ? 8'h3F : 8'hFF;
            checks++;
            if ({line_cnt, odd_line, r} !== {10'(ln), 1'(ln % 2), exp_r}) begin
                failures++;
                $display("FAIL latch_line%0d got=%h exp=%h", ln, {line_cnt, odd_line, r},
                         {10'(ln), 1'(ln % 2), exp_r});
            end
            hs_pulse();
        end
        sl_mode = 2'd0;
    endtask

    task automatic test_same_edge();
        vs_pulse();
        hs_pulse(); hs_pulse(); hs_pulse();
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00); step();
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00); step();
        checks++;
        if ({hs, vs, line_cnt, odd_line} !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
            failures++;
            $display("FAIL same_edge got=%h exp=%h", {hs, vs, line_cnt, odd_line},
                     {1'b1, 1'b1, 10'd0, 1'b0});
        end
    endtask

    task automatic test_saturate();
        vs_pulse();
        for (int i = 0; i < 1023; i++) hs_pulse();
        pix(8'h01, 8'h02, 8'h03);
        checks++;
        if (line_cnt !== 10'd1023) begin
            failures++;
            $display("FAIL sat_reach got=%0d exp=%0d", line_cnt, 1023);
        end
        for (int i = 0; i < 77; i++) hs_pulse();
        pix(8'h01, 8'h02, 8'h03);
        checks++;
        if (line_cnt !== 10'd1023) begin
            failures++;
            $display("FAIL sat_hold got=%0d exp=%0d", line_cnt, 1023);
        end
    endtask

    task automatic test_reset_midline();
        logic [23:0] exp_rgb;
        vs_pulse();
        hs_pulse(); hs_pulse();
        pix(8'hAA, 8'hBB, 8'hCC);
        pce = 1'b0;
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
        step();
        checks++;
        if ({hs, vs, de, hblank, vblank, odd_line, line_cnt, r, g, b} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 24'h0}) begin
            failures++;
            $display("FAIL reset_midline got=%h exp=%h",
                     {hs, vs, de, hblank, vblank, odd_line, line_cnt, r, g, b},
                     {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 24'h0});
        end
        reset_n = 1'b1;
        pce = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00); step();
        sl_mode = 2'd2;
        vs_pulse();
        pix(8'hFF, 8'h80, 8'h03);
        checks++;
        if ({vblank, de, line_cnt, odd_line, r, g, b} !== {1'b0, 1'b1, 10'd0, 1'b0, 24'hFF8003}) begin
            failures++;
            $display("FAIL post_reset_line0 got=%h exp=%h", {vblank, de, line_cnt, odd_line, r, g, b},
                     {1'b0, 1'b1, 10'd0, 1'b0, 24'hFF8003});
        end
        hs_pulse();
        pix(8'hFF, 8'h80, 8'h03);
        exp_rgb = FX ? 24'h7F4001 : 24'hFF8003;
        checks++;
        if ({line_cnt, odd_line, r, g, b} !== {10'd1, 1'b1, exp_rgb}) begin
            failures++;
            $display("FAIL post_reset_line1 got=%h exp=%h", {line_cnt, odd_line, r, g, b},
                     {10'd1, 1'b1, exp_rgb});
        end
        hs_pulse();
        pix(8'h40, 8'h40, 8'h40);
        checks++;
        if ({line_cnt, odd_line, r, g, b} !== {10'd2, 1'b0, 24'h404040}) begin
            failures++;
            $display("FAIL post_reset_line2 got=%h exp=%h", {line_cnt, odd_line, r, g, b},
                     {10'd2, 1'b0, 24'h404040});
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pce = 1'b1;
        sl_mode = 2'd0;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        step();
        test_reset();
        test_latency();
        test_shade();
        test_mode_latch();
        test_same_edge();
        test_saturate();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
